// File: rtl/json_stream_arbiter_if.sv
// rtl/json_stream_arbiter_if.sv - source streams and parser-side pins of the json parser arbiter
interface json_stream_arbiter_if;
    logic [7:0] s0_char;
    logic       s0_valid;
    logic       s0_ready;
    logic [7:0] s1_char;
    logic       s1_valid;
    logic       s1_ready;
    logic [7:0] p_char;
    logic       p_reset;
    logic [1:0] owner;
    logic       obj_done;
    logic       obj_abort;
    logic       done_src;

    modport master (
        output s0_char, s0_valid, s1_char, s1_valid,
        input  s0_ready, s1_ready, p_char, p_reset, owner, obj_done, obj_abort, done_src
    );

    modport slave (
        input  s0_char, s0_valid, s1_char, s1_valid,
        output s0_ready, s1_ready, p_char, p_reset, owner, obj_done, obj_abort, done_src
    );
endinterface

// File: rtl/json_stream_arbiter.sv
// rtl/json_stream_arbiter.sv - grants one json parser to two char sources, one whole object at a time
// Optional stall timeout/abort enabled by defining JSON_ARB_TIMEOUT_EN.
module json_stream_arbiter #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [7:0]  IDLE_CHAR = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    json_stream_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SWITCH, ST_BUSY} state_t;

    localparam logic [7:0] CH_QUOTE = 8'h22;
    localparam logic [7:0] CH_CLOSE = 8'h7d;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_owner_q, last_owner_d;
    logic       rr_q, rr_d;
    logic       in_str_q, in_str_d;
    logic [7:0] p_char_q, p_char_d;
    logic       p_reset_q, p_reset_d;
    logic       obj_done_q, obj_done_d;
    logic       obj_abort_q, obj_abort_d;
    logic       done_src_q, done_src_d;
`ifdef JSON_ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);
    logic [7:0] stall_cnt_q, stall_cnt_d;
`endif

    logic       own_valid;
    logic [7:0] own_char;
    logic       accept;
    logic       pick_src;
    logic [1:0] pick_owner;

    always_comb begin
        own_valid  = owner_q[1] ? bus.s1_valid : bus.s0_valid;
        own_char   = owner_q[1] ? bus.s1_char  : bus.s0_char;
        accept     = (state_q == ST_BUSY) && own_valid;
        // Contention goes to rr; otherwise whichever source is asking.
        pick_src   = (bus.s0_valid && bus.s1_valid) ? rr_q : bus.s1_valid;
        pick_owner = pick_src ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rr_d         = rr_q;
        in_str_d     = in_str_q;
        p_char_d     = IDLE_CHAR;
        p_reset_d    = 1'b0;
        obj_done_d   = 1'b0;
        obj_abort_d  = 1'b0;
        done_src_d   = done_src_q;
`ifdef JSON_ARB_TIMEOUT_EN
        stall_cnt_d  = stall_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.s0_valid || bus.s1_valid) begin
                    owner_d = pick_owner;
                    state_d = (pick_owner == last_owner_q) ? ST_BUSY : ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                p_reset_d    = 1'b1;
                last_owner_d = owner_q;
                in_str_d     = 1'b0;
                state_d      = ST_BUSY;
            end
            ST_BUSY: begin
                if (accept) begin
                    p_char_d = own_char;
`ifdef JSON_ARB_TIMEOUT_EN
                    stall_cnt_d = 8'd0;
`endif
                    // A closing brace inside a quoted string is payload, not the end.
                    if (own_char == CH_QUOTE) begin
                        in_str_d = ~in_str_q;
                    end else if (own_char == CH_CLOSE && !in_str_q) begin
                        obj_done_d = 1'b1;
                        done_src_d = owner_q[1];
                        rr_d       = ~owner_q[1];
                        owner_d    = 2'b00;
                        state_d    = ST_IDLE;
                    end
                end
`ifdef JSON_ARB_TIMEOUT_EN
                else if (stall_cnt_q == STALL_LIMIT) begin
                    // Forget the owner so the next grant always re-resets the parser.
                    p_reset_d    = 1'b1;
                    obj_abort_d  = 1'b1;
                    done_src_d   = owner_q[1];
                    rr_d         = ~owner_q[1];
                    last_owner_d = 2'b00;
                    owner_d      = 2'b00;
                    stall_cnt_d  = 8'd0;
                    state_d      = ST_IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 2'b00;
            last_owner_q <= 2'b00;
            rr_q         <= 1'b0;
            in_str_q     <= 1'b0;
            p_char_q     <= IDLE_CHAR;
            p_reset_q    <= 1'b1;
            obj_done_q   <= 1'b0;
            obj_abort_q  <= 1'b0;
            done_src_q   <= 1'b0;
`ifdef JSON_ARB_TIMEOUT_EN
            stall_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rr_q         <= rr_d;
            in_str_q     <= in_str_d;
            p_char_q     <= p_char_d;
            p_reset_q    <= p_reset_d;
            obj_done_q   <= obj_done_d;
            obj_abort_q  <= obj_abort_d;
            done_src_q   <= done_src_d;
`ifdef JSON_ARB_TIMEOUT_EN
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    assign bus.s0_ready  = (state_q == ST_BUSY) && (owner_q == 2'b01);
    assign bus.s1_ready  = (state_q == ST_BUSY) && (owner_q == 2'b10);
    assign bus.p_char    = p_char_q;
    assign bus.p_reset   = p_reset_q;
    assign bus.owner     = owner_q;
    assign bus.obj_done  = obj_done_q;
    assign bus.obj_abort = obj_abort_q;
    assign bus.done_src  = done_src_q;
endmodule

// File: doc/json_stream_arbiter.md
Name: json_stream_arbiter

Overview:
- Shares one `json` parser instance (char/cur_num/max_num/status) between two character-stream requesters.
- Grants the parser for a whole object at a time, from acceptance of the first char up to and including the unquoted closing `}`.
- Pulses the parser's reset whenever ownership changes, so parser state never mixes between sources.
- Sits between the stream sources and the parser, driving the parser's `char` and `reset` pins.

Parameters:
- TIMEOUT, 16: consecutive stall cycles tolerated from the granted source mid-object before abort (1..255).
- IDLE_CHAR, 8'h00: value driven on p_char on cycles with no accepted char; the parser treats it as a no-op.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- s0_char  input  8  source 0 character
- s0_valid  input  1  source 0 char valid
- s0_ready  output  1  source 0 char accepted this cycle when valid&ready
- s1_char  input  8  source 1 character
- s1_valid  input  1  source 1 char valid
- s1_ready  output  1  source 1 char accepted this cycle when valid&ready
- p_char  output  8  registered char to parser `char`
- p_reset  output  1  registered reset to parser `reset`
- owner  output  2  2'b00 none, 2'b01 src0, 2'b10 src1 (current grant)
- obj_done  output  1  one-cycle pulse: closing `}` forwarded
- obj_abort  output  1  one-cycle pulse: object aborted by timeout
- done_src  output  1  source index for obj_done/obj_abort

Behaviour:
- Reset values: p_char=IDLE_CHAR, p_reset=1, owner=0, obj_done=0, obj_abort=0, done_src=0, s*_ready=0.
- Internal reset values: state=IDLE, last_owner=none, rr=0, in_str=0, stall_cnt=0.
- FSM: IDLE, SWITCH, BUSY.
- IDLE:
  - If only one s*_valid is high, pick that source; if both, pick rr.
  - If the picked source == last_owner, go BUSY with no parser reset; otherwise go SWITCH.
  - owner is set on entering SWITCH/BUSY.
- SWITCH (exactly 1 cycle): p_reset=1 on the next clock edge; last_owner updated; in_str cleared; then BUSY.
- BUSY:
  - s_ready of the owner is high (combinational from state/owner); the other source's ready is 0.
  - On accept: p_char <= s_char at the next edge (1-cycle latency char-in to parser pin).
  - If the char is 8'h22, in_str toggles.
  - If the char is `}` with in_str=0: the object ends. obj_done=1 and done_src=owner on the same edge that p_char carries `}`. rr flips to the other source, owner=0, state IDLE.
  - Every cycle with no accepted char drives p_char=IDLE_CHAR.
- ready is never asserted in IDLE/SWITCH, so no char is dropped or duplicated.
- Back-to-back: a new grant is evaluated in the IDLE cycle after obj_done, so a minimum of 1 bubble cycle per object on the same source and 2 bubble cycles on a switch.
- stall_cnt:
  - Counts consecutive BUSY cycles with owner valid=0; it is cleared on every accept.
  - Abort behaviour is defined under Optional Feature.
- The other source asserting valid during BUSY has no effect until IDLE (no preemption).
- Reset asserted mid-object: everything returns to reset values immediately (synchronous); p_reset=1 resets the parser too.
- obj_done and obj_abort are never high together.

Optional Feature:
- Macro: JSON_ARB_TIMEOUT_EN.
- Defined:
  - When stall_cnt reaches TIMEOUT, the next edge gives p_reset=1, obj_abort=1, done_src=owner.
  - rr flips, last_owner=none (the next grant always passes through SWITCH), state IDLE.
  - The partial object is discarded.
- Undefined: no counter exists; the grant is held indefinitely, and obj_abort is tied to 0.

Test Plan:
- Reset then s0 sends `{"k":"v"}` continuously → SWITCH cycle with p_reset=1. The 9 chars appear on p_char 1 cycle after each accept. obj_done=1 with done_src=0 on the `}` cycle; owner returns to 0.
- Both valid in the same IDLE cycle with rr=0 → s0 granted. After its `}`, s1 (still valid) is granted via SWITCH (p_reset pulse); s0 ready=0 throughout s1's object.
- s0 sends `{"}":"v"}` → the quoted `}` does not end the object. obj_done fires only on the final `}`, after 9 chars forwarded.
- s0 sends `{}` twice back-to-back with s1 idle → second grant skips SWITCH (no p_reset). The parser sees `{`,`}`,IDLE,`{`,`}`.
- With JSON_ARB_TIMEOUT_EN and TIMEOUT=16: s0 sends `{"k` then drops valid → after 16 stall cycles obj_abort=1 and p_reset=1. The next s0 grant passes through SWITCH. Without the macro, owner stays 2'b01 for 100+ cycles.
- Reset asserted while s1 is mid-object → next cycle owner=0, p_reset=1, s1_ready=0, p_char=IDLE_CHAR.
